ps2_key_controller: RTL and testbench

//   Sequences the raw PS/2 byte stream from PS2Receiver into game control state for both players.

---
 rtl/ps2_key_pkg.sv | 52 +++++
 rtl/ps2_scancode_map.sv | 34 +++
 rtl/ps2_key_controller.sv | 194 +++++++++++++++++++
 tb/tb_ps2_key_controller.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_pkg.sv
// Shared scancodes, key indices and FSM states for the PS/2 game-control path.
// Imported by the scancode map and by the controller top.
package ps2_key_pkg;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;
    localparam logic [7:0] SC_E1    = 8'hE1;
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam int K_NUM = 10;

    typedef enum logic [3:0] {
        K_W     = 4'd0,
        K_A     = 4'd1,
        K_S     = 4'd2,
        K_D     = 4'd3,
        K_UP    = 4'd4,
        K_LEFT  = 4'd5,
        K_DOWN  = 4'd6,
        K_RIGHT = 4'd7,
        K_SPACE = 4'd8,
        K_ESC   = 4'd9
    } key_idx_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } ps2_state_e;

    // Keyboard housekeeping bytes (BAT, ack, echo, resend, error) carry no key meaning.
    function automatic logic is_discard(input logic [7:0] b);
        logic r;
        case (b)
            8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ps2_scancode_map.sv
// Combinational lookup from (extended flag, scancode byte) to a tracked key index.
// Standard codes only match with ext=0 and arrow codes only with ext=1.
module ps2_scancode_map
    import ps2_key_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output logic       hit,
    output key_idx_e   idx
);

    // Decode the prefixed byte into a key slot.
    always_comb begin
        hit = 1'b1;
        idx = K_W;
        case ({ext, code})
            {1'b0, SC_W}:     idx = K_W;
            {1'b0, SC_A}:     idx = K_A;
            {1'b0, SC_S}:     idx = K_S;
            {1'b0, SC_D}:     idx = K_D;
            {1'b0, SC_SPACE}: idx = K_SPACE;
            {1'b0, SC_ESC}:   idx = K_ESC;
            {1'b1, SC_UP}:    idx = K_UP;
            {1'b1, SC_LEFT}:  idx = K_LEFT;
            {1'b1, SC_DOWN}:  idx = K_DOWN;
            {1'b1, SC_RIGHT}: idx = K_RIGHT;
            default: begin
                hit = 1'b0;
                idx = K_W;
            end
        endcase
    end

endmodule

// File: rtl/ps2_key_controller.sv
// Turns the PS2Receiver byte stream into held-key state for two players
// plus single-cycle start/pause pulses that ignore typematic repeats.
module ps2_key_controller
    import ps2_key_pkg::*;
#(
    parameter int E1_SKIP   = 7,
    parameter int FLAG_SYNC = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] keycode,
    input  logic        key_flag,
    output logic [3:0]  p1_dir,
    output logic [3:0]  p2_dir,
    output logic        start_pulse,
    output logic        pause_pulse,
    output logic        any_held
);

    logic             flag_s;
    logic             flag_q_r;
    logic             byte_stb_s;
    logic [7:0]       byte_s;
    logic             unused_s;

    ps2_state_e       state_r;
    ps2_state_e       state_nxt_s;
    logic [7:0]       skip_cnt_r;
    logic [7:0]       skip_nxt_s;
    logic             ext_s;
    logic             make_s;
    logic             brk_s;

    logic             map_hit_s;
    key_idx_e         map_idx_s;

    logic [K_NUM-1:0] held_r;
    logic [K_NUM-1:0] held_nxt_s;
    logic             any_held_r;
    logic             start_r;
    logic             start_nxt_s;
    logic             pause_r;
    logic             pause_nxt_s;

    assign unused_s = ^keycode[15:8];
    assign byte_s   = keycode[7:0];

    // Sync flops reset high so a flag already high at reset release never looks like a new byte.
    generate
        if (FLAG_SYNC != 0) begin : g_sync
            logic [1:0] sync_r;
            // Two-flop synchroniser for the slower-domain flag.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync_r <= 2'b11;
                end else begin
                    sync_r <= {sync_r[0], key_flag};
                end
            end
            assign flag_s = sync_r[1];
        end else begin : g_nosync
            assign flag_s = key_flag;
        end
    endgenerate

    // Previous flag sample for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flag_q_r <= 1'b1;
        end else begin
            flag_q_r <= flag_s;
        end
    end

    assign byte_stb_s = flag_s & ~flag_q_r;
    assign ext_s      = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);

    ps2_scancode_map u_map (
        .ext  (ext_s),
        .code (byte_s),
        .hit  (map_hit_s),
        .idx  (map_idx_s)
    );

    // FSM state and E1 skip counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            skip_cnt_r <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            skip_cnt_r <= skip_nxt_s;
        end
    end

    // Prefix sequencing: decides whether the current byte is a make, a break or ignored.
    always_comb begin
        state_nxt_s = state_r;
        skip_nxt_s  = skip_cnt_r;
        make_s      = 1'b0;
        brk_s       = 1'b0;
        if (byte_stb_s) begin
            case (state_r)
                ST_IDLE: begin
                    if (is_discard(byte_s)) begin
                        state_nxt_s = ST_IDLE;
                    end else if (byte_s == SC_E0) begin
                        state_nxt_s = ST_EXT;
                    end else if (byte_s == SC_F0) begin
                        state_nxt_s = ST_BRK;
                    end else if (byte_s == SC_E1) begin
                        state_nxt_s = ST_SKIP;
                        skip_nxt_s  = 8'(E1_SKIP);
                    end else begin
                        make_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (is_discard(byte_s)) begin
                        state_nxt_s = ST_IDLE;
                    end else if (byte_s == SC_F0) begin
                        state_nxt_s = ST_EXT_BRK;
                    end else if (byte_s == SC_E0) begin
                        state_nxt_s = ST_EXT;
                    end else begin
                        make_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    // A second prefix here is a protocol error: drop it rather than reinterpret.
                    state_nxt_s = ST_IDLE;
                    if (is_discard(byte_s) || (byte_s == SC_E0) || (byte_s == SC_F0)) begin
                        brk_s = 1'b0;
                    end else begin
                        brk_s = 1'b1;
                    end
                end
                ST_SKIP: begin
                    if (skip_cnt_r <= 8'd1) begin
                        skip_nxt_s  = 8'd0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        skip_nxt_s  = skip_cnt_r - 8'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    skip_nxt_s  = 8'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Held-bit update and 0->1 pulse qualification.
    always_comb begin
        held_nxt_s  = held_r;
        start_nxt_s = 1'b0;
        pause_nxt_s = 1'b0;
        if (map_hit_s && make_s) begin
            held_nxt_s[map_idx_s] = 1'b1;
            start_nxt_s = (map_idx_s == K_SPACE) && !held_r[K_SPACE];
            pause_nxt_s = (map_idx_s == K_ESC) && !held_r[K_ESC];
        end else if (map_hit_s && brk_s) begin
            held_nxt_s[map_idx_s] = 1'b0;
        end else begin
            held_nxt_s = held_r;
        end
    end

    // Output-side registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            held_r     <= '0;
            any_held_r <= 1'b0;
            start_r    <= 1'b0;
            pause_r    <= 1'b0;
        end else begin
            held_r     <= held_nxt_s;
            any_held_r <= |held_nxt_s;
            start_r    <= start_nxt_s;
            pause_r    <= pause_nxt_s;
        end
    end

    assign p1_dir      = {held_r[K_W], held_r[K_A], held_r[K_S], held_r[K_D]};
    assign p2_dir      = {held_r[K_UP], held_r[K_LEFT], held_r[K_DOWN], held_r[K_RIGHT]};
    assign start_pulse = start_r;
    assign pause_pulse = pause_r;
    assign any_held    = any_held_r;

endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller: scancode sequences with hand-computed
// held-key and pulse expectations.
module tb_ps2_key_controller;

    logic        clk;
    logic        rst_n;
    logic [15:0] keycode;
    logic        key_flag;
    logic [3:0]  p1_dir;
    logic [3:0]  p2_dir;
    logic        start_pulse;
    logic        pause_pulse;
    logic        any_held;

    int tests_run    = 0;
    int tests_failed = 0;
    int start_cnt    = 0;
    int pause_cnt    = 0;
    int wide_cnt     = 0;
    logic start_prev = 1'b0;
    logic pause_prev = 1'b0;

    ps2_key_controller #(.E1_SKIP(7), .FLAG_SYNC(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .keycode     (keycode),
        .key_flag    (key_flag),
        .p1_dir      (p1_dir),
        .p2_dir      (p2_dir),
        .start_pulse (start_pulse),
        .pause_pulse (pause_pulse),
        .any_held    (any_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge; also catch any pulse lasting 2+ cycles.
    always @(negedge clk) begin
        if (start_pulse) start_cnt = start_cnt + 1;
        if (pause_pulse) pause_cnt = pause_cnt + 1;
        if ((start_pulse && start_prev) || (pause_pulse && pause_prev)) wide_cnt = wide_cnt + 1;
        start_prev = start_pulse;
        pause_prev = pause_pulse;
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        keycode  = {8'h00, b};
        key_flag = 1'b1;
        repeat (4) @(negedge clk);
        key_flag = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        key_flag = 1'b1;
        keycode  = 16'h001D;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({p1_dir, p2_dir, start_pulse, pause_pulse, any_held} !== 11'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs got %b want 0", {p1_dir, p2_dir, start_pulse, pause_pulse, any_held});
        end
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        tests_run++;
        if (p1_dir !== 4'b0000 || any_held !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flag_high p1_dir got %b want 0000 any_held %b", p1_dir, any_held);
        end
        key_flag = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_latency();
        @(negedge clk);
        keycode  = 16'h0023;
        key_flag = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (p1_dir !== 4'b0000) begin
            tests_failed++;
            $display("FAIL latency_early p1_dir got %b want 0000", p1_dir);
        end
        @(negedge clk);
        tests_run++;
        if (p1_dir !== 4'b0001 || any_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_3clk p1_dir got %b want 0001 any_held %b", p1_dir, any_held);
        end
        repeat (2) @(negedge clk);
        key_flag = 1'b0;
        repeat (4) @(negedge clk);
        send_byte(8'hF0);
        send_byte(8'h23);
        tests_run++;
        if (p1_dir !== 4'b0000 || any_held !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_break p1_dir got %b want 0000 any_held %b", p1_dir, any_held);
        end
    endtask

    task automatic test_p1_make_break();
        send_byte(8'h1D);
        tests_run++;
        if (p1_dir !== 4'b1000) begin
            tests_failed++;
            $display("FAIL t1_make p1_dir got %b want 1000", p1_dir);
        end
        send_byte(8'hF0);
        send_byte(8'h1D);
        tests_run++;
        if (p1_dir !== 4'b0000) begin
            tests_failed++;
            $display("FAIL t1_break p1_dir got %b want 0000", p1_dir);
        end
    endtask

    task automatic test_p2_arrow();
        send_byte(8'hE0);
        send_byte(8'h6B);
        tests_run++;
        if (p2_dir !== 4'b0100 || p1_dir !== 4'b0000) begin
            tests_failed++;
            $display("FAIL t2_make p2_dir got %b want 0100 p1_dir got %b want 0000", p2_dir, p1_dir);
        end
        send_byte(8'hE0);
        send_byte(8'h6B);
        tests_run++;
        if (p2_dir !== 4'b0100 || p1_dir !== 4'b0000) begin
            tests_failed++;
            $display("FAIL t2_repeat p2_dir got %b want 0100 p1_dir got %b want 0000", p2_dir, p1_dir);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h6B);
        tests_run++;
        if (p2_dir !== 4'b0000 || p1_dir !== 4'b0000 || any_held !== 1'b0) begin
            tests_failed++;
            $display("FAIL t2_break p2_dir got %b want 0000 p1_dir %b any_held %b", p2_dir, p1_dir, any_held);
        end
    endtask

    task automatic test_start_pulse();
        int base;
        int wbase;
        logic [7:0] seq [7];
        seq = '{8'h29, 8'h29, 8'h29, 8'hF0, 8'h29, 8'h29, 8'h00};
        base  = start_cnt;
        wbase = wide_cnt;
        for (int i = 0; i < 6; i++) send_byte(seq[i]);
        tests_run++;
        if (start_cnt - base !== 2) begin
            tests_failed++;
            $display("FAIL t3_start_count got %0d want 2", start_cnt - base);
        end
        tests_run++;
        if (wide_cnt - wbase !== 0) begin
            tests_failed++;
            $display("FAIL t3_pulse_width wide pulses got %0d want 0", wide_cnt - wbase);
        end
        tests_run++;
        if (any_held !== 1'b1 || p1_dir !== 4'b0000) begin
            tests_failed++;
            $display("FAIL t3_space_held any_held got %b want 1 p1_dir %b", any_held, p1_dir);
        end
        send_byte(8'hF0);
        send_byte(8'h29);
    endtask

    task automatic test_pause_pulse();
        int base;
        base = pause_cnt;
        send_byte(8'h76);
        send_byte(8'h76);
        tests_run++;
        if (pause_cnt - base !== 1) begin
            tests_failed++;
            $display("FAIL pause_count got %0d want 1", pause_cnt - base);
        end
        send_byte(8'hF0);
        send_byte(8'h76);
        tests_run++;
        if (any_held !== 1'b0 || pause_cnt - base !== 1) begin
            tests_failed++;
            $display("FAIL pause_release any_held got %b want 0 pulses %0d want 1", any_held, pause_cnt - base);
        end
    endtask

    task automatic test_e1_skip();
        int sbase;
        int pbase;
        logic [7:0] seq [8];
        seq   = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        sbase = start_cnt;
        pbase = pause_cnt;
        for (int i = 0; i < 8; i++) begin
            send_byte(seq[i]);
            tests_run++;
            if ({p1_dir, p2_dir, any_held} !== 9'd0 || start_cnt != sbase || pause_cnt != pbase) begin
                tests_failed++;
                $display("FAIL t4_skip_byte%0d outputs got %b want 0", i, {p1_dir, p2_dir, any_held});
            end
        end
        send_byte(8'h1C);
        tests_run++;
        if (p1_dir !== 4'b0100) begin
            tests_failed++;
            $display("FAIL t4_after_skip p1_dir got %b want 0100", p1_dir);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
    endtask

    task automatic test_reset_mid_sequence();
        send_byte(8'h1D);
        send_byte(8'hF0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        tests_run++;
        if ({p1_dir, p2_dir, start_pulse, pause_pulse, any_held} !== 11'd0) begin
            tests_failed++;
            $display("FAIL t5_reset outputs got %b want 0", {p1_dir, p2_dir, start_pulse, pause_pulse, any_held});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_byte(8'h1B);
        tests_run++;
        if (p1_dir !== 4'b0010 || any_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL t5_make_after_reset p1_dir got %b want 0010 any_held %b", p1_dir, any_held);
        end
        send_byte(8'hF0);
        send_byte(8'h1B);
    endtask

    task automatic test_discard_and_error();
        logic [7:0] seq [7];
        seq = '{8'h1D, 8'h23, 8'hAA, 8'hFA, 8'hF0, 8'hE0, 8'h75};
        for (int i = 0; i < 2; i++) send_byte(seq[i]);
        tests_run++;
        if (p1_dir !== 4'b1001) begin
            tests_failed++;
            $display("FAIL t6_setup p1_dir got %b want 1001", p1_dir);
        end
        for (int i = 2; i < 7; i++) send_byte(seq[i]);
        tests_run++;
        if (p1_dir !== 4'b1001) begin
            tests_failed++;
            $display("FAIL t6_p1 p1_dir got %b want 1001", p1_dir);
        end
        tests_run++;
        if (p2_dir !== 4'b0000) begin
            tests_failed++;
            $display("FAIL t6_p2 p2_dir got %b want 0000", p2_dir);
        end
        tests_run++;
        if (any_held !== 1'b1) begin
            tests_failed++;
            $display("FAIL t6_any_held got %b want 1", any_held);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        key_flag = 1'b0;
        keycode  = 16'h0000;
        test_reset();
        test_latency();
        test_p1_make_break();
        test_p2_arrow();
        test_start_pulse();
        test_pause_pulse();
        test_e1_skip();
        test_reset_mid_sequence();
        test_discard_and_error();
        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
